// File: rtl/data_obi_initiator.sv
// Bench-side OBI data requester: one address phase at a time, in-order tracking of
// granted transactions, response pulses paired with request metadata, sticky error flags.
module data_obi_initiator #(
  parameter int DW        = 65,
  parameter int MAX_OUTST = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [3:0]    cmd_be,
  input  logic          cmd_is_cap,
  input  logic [31:0]   cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  input  logic [7:0]    cmd_flag,
  output logic          data_req,
  output logic          data_we,
  output logic [3:0]    data_be,
  output logic          data_is_cap,
  output logic [31:0]   data_addr,
  output logic [DW-1:0] data_wdata,
  output logic [7:0]    data_flag,
  input  logic          data_gnt,
  input  logic          data_rvalid,
  input  logic [DW-1:0] data_rdata,
  input  logic          data_err,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic          resp_we,
  output logic [31:0]   resp_addr,
  output logic [2:0]    outst_cnt,
  output logic          proto_err,
  output logic          timeout_err
);

  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] LAST = PW'(MAX_OUTST - 1);
  localparam logic [2:0]    MAXC = 3'(MAX_OUTST);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  logic          r_fifo_we   [2**PW];
  logic [31:0]   r_fifo_addr [2**PW];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [TW-1:0] r_tmo;

  logic w_accept;
  logic w_hs;
  logic w_pop;
  logic w_orphan;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign cmd_ready = ~data_req & (outst_cnt < MAXC);
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_hs      = data_req & data_gnt;
  // Occupancy is sampled before any same-cycle grant, so a pop only hits an existing entry.
  assign w_pop     = data_rvalid & (outst_cnt != 3'd0);
  assign w_orphan  = data_rvalid & (outst_cnt == 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_req    <= 1'b0;
      data_we     <= 1'b0;
      data_be     <= '0;
      data_is_cap <= 1'b0;
      data_addr   <= '0;
      data_wdata  <= '0;
      data_flag   <= '0;
    end else if (w_accept) begin
      data_req    <= 1'b1;
      data_we     <= cmd_we;
      data_be     <= cmd_be;
      data_is_cap <= cmd_is_cap;
      data_addr   <= cmd_addr;
      data_wdata  <= cmd_wdata;
      data_flag   <= cmd_flag;
    end else if (w_hs) begin
      data_req    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_fifo_we[r_wptr]   <= data_we;
      r_fifo_addr[r_wptr] <= data_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      outst_cnt <= '0;
    end else begin
      if (w_hs)  r_wptr <= f_inc(r_wptr);
      if (w_pop) r_rptr <= f_inc(r_rptr);
      case ({w_hs, w_pop})
        2'b10:   outst_cnt <= outst_cnt + 3'd1;
        2'b01:   outst_cnt <= outst_cnt - 3'd1;
        default: outst_cnt <= outst_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      resp_we    <= 1'b0;
      resp_addr  <= '0;
    end else begin
      resp_valid <= w_pop;
      if (w_pop) begin
        resp_rdata <= data_rdata;
        resp_err   <= data_err;
        resp_we    <= r_fifo_we[r_rptr];
        resp_addr  <= r_fifo_addr[r_rptr];
      end
    end
  end

  // Watchdog saturates at TIMEOUT; both error flags are sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo       <= '0;
      proto_err   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (w_orphan) proto_err <= 1'b1;
      if (data_rvalid || (outst_cnt == 3'd0)) begin
        r_tmo <= '0;
      end else if (r_tmo != TMAX) begin
        r_tmo <= r_tmo + 1'b1;
        if (r_tmo == TMAX - 1'b1) timeout_err <= 1'b1;
      end
    end
  end

endmodule
